// File: rtl/fx_pkg.sv
// Shared definitions for the fixed-point unit writeback path:
// functional-unit codes, the datapath width and the queued writeback entry.
package fx_pkg;

    localparam int DATA_W     = 64;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        UNIT_FX  = 3'd0,
        UNIT_LS  = 3'd1,
        UNIT_BR  = 3'd2,
        UNIT_CR  = 3'd3,
        UNIT_FP  = 3'd4,
        UNIT_VEC = 3'd5
    } unit_code_e;

    // Data fields use big-endian numbering: bit 0 is the MSB.
    typedef struct packed {
        logic                  reg1_en;
        logic [REG_ADDR_W-1:0] reg1_addr;
        logic [0:DATA_W-1]     reg1_val;
        logic                  reg2_en;
        logic [REG_ADDR_W-1:0] reg2_addr;
        logic [0:DATA_W-1]     reg2_val;
    } wb_entry_t;

    // A result is queued only if it comes from our unit and writes something.
    function automatic logic is_fx_writeback(
        input logic       valid,
        input logic [2:0] unit_code,
        input logic [2:0] fx_code,
        input logic       reg1_en,
        input logic       reg2_en
    );
        return valid && (unit_code == fx_code) && (reg1_en || reg2_en);
    endfunction

endpackage

// File: rtl/fx_wb_fifo_ctrl.sv
// Pointer, occupancy and overflow bookkeeping for the writeback buffer.
// Storage lives in the parent; this block only decides when to push and pop.
module fx_wb_fifo_ctrl
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_req,
    input  logic             write_ready,
    output logic             push,
    output logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A full buffer can still take a push when the head retires in the same cycle.
    assign pop  = !empty && write_ready;
    assign push = push_req && (!full || pop);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (push_req && !push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fx_writeback_buffer.sv
// In-order writeback queue between the fixed-point unit and the GPR/CR write port.
// Define FXWB_FORWARD_EN to add the GPR forwarding lookup (fwdAddr_i/fwdHit_o/fwdVal_o).
module fx_writeback_buffer
    import fx_pkg::*;
#(
    parameter int         regWidth   = 5,
    parameter int         DEPTH      = 4,
    parameter logic [2:0] FXUnitCode = UNIT_FX
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [2:0]             functionalUnitCode_i,
    input  logic                   reg1WritebackEnable_i,
    input  logic [regWidth-1:0]    reg1WritebackAddress_i,
    input  logic [0:DATA_W-1]      reg1WritebackVal_i,
    input  logic                   reg2WritebackEnable_i,
    input  logic [regWidth-1:0]    reg2WritebackAddress_i,
    input  logic [0:DATA_W-1]      reg2WritebackVal_i,
    input  logic                   writeReady_i,
    output logic                   gprWriteEnable_o,
    output logic [regWidth-1:0]    gprWriteAddress_o,
    output logic [0:DATA_W-1]      gprWriteVal_o,
    output logic                   crWriteEnable_o,
    output logic [regWidth-1:0]    crWriteAddress_o,
    output logic [0:DATA_W-1]      crWriteVal_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o
`ifdef FXWB_FORWARD_EN
    ,
    input  logic [regWidth-1:0]    fwdAddr_i,
    output logic                   fwdHit_o,
    output logic [0:DATA_W-1]      fwdVal_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             push_req;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             overflow;

    wb_entry_t        mem [DEPTH];
    wb_entry_t        new_entry;
    wb_entry_t        head;

    assign push_req = is_fx_writeback(enable_i, functionalUnitCode_i, FXUnitCode,
                                      reg1WritebackEnable_i, reg2WritebackEnable_i);

    fx_wb_fifo_ctrl #(
        .DEPTH(DEPTH)
    ) u_ctrl (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .push_req    (push_req),
        .write_ready (writeReady_i),
        .push        (push),
        .pop         (pop),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow)
    );

    // Address fields are sized by the package; regWidth must not exceed REG_ADDR_W.
    always_comb begin
        new_entry           = '0;
        new_entry.reg1_en   = reg1WritebackEnable_i;
        new_entry.reg1_addr = REG_ADDR_W'(reg1WritebackAddress_i);
        new_entry.reg1_val  = reg1WritebackVal_i;
        new_entry.reg2_en   = reg2WritebackEnable_i;
        new_entry.reg2_addr = REG_ADDR_W'(reg2WritebackAddress_i);
        new_entry.reg2_val  = reg2WritebackVal_i;
    end

    // Storage needs no reset: nothing is visible until count marks it valid.
    always_ff @(posedge clock_i) begin
        if (push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    assign head = mem[rd_ptr];

    assign gprWriteEnable_o  = !empty && head.reg1_en;
    assign gprWriteAddress_o = gprWriteEnable_o ? regWidth'(head.reg1_addr) : '0;
    assign gprWriteVal_o     = gprWriteEnable_o ? head.reg1_val : '0;
    assign crWriteEnable_o   = !empty && head.reg2_en;
    assign crWriteAddress_o  = crWriteEnable_o ? regWidth'(head.reg2_addr) : '0;
    assign crWriteVal_o      = crWriteEnable_o ? head.reg2_val : '0;

    assign full_o     = full;
    assign empty_o    = empty;
    assign count_o    = count;
    assign overflow_o = overflow;

`ifdef FXWB_FORWARD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        fwdHit_o = 1'b0;
        fwdVal_o = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && mem[fwd_idx].reg1_en &&
                (regWidth'(mem[fwd_idx].reg1_addr) == fwdAddr_i)) begin
                fwdHit_o = 1'b1;
                fwdVal_o = mem[fwd_idx].reg1_val;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fx_writeback_buffer.sv
// Self-checking bench for fx_writeback_buffer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_fx_writeback_buffer;

    localparam int REGW  = 5;
    localparam int DEPTH = 4;

    typedef struct {
        logic        e1;
        logic [4:0]  a1;
        logic [63:0] v1;
        logic        e2;
        logic [4:0]  a2;
        logic [63:0] v2;
    } ent_t;

    logic            clock_i;
    logic            reset_i;
    logic            enable_i;
    logic [2:0]      functionalUnitCode_i;
    logic            reg1WritebackEnable_i;
    logic [REGW-1:0] reg1WritebackAddress_i;
    logic [63:0]     reg1WritebackVal_i;
    logic            reg2WritebackEnable_i;
    logic [REGW-1:0] reg2WritebackAddress_i;
    logic [63:0]     reg2WritebackVal_i;
    logic            writeReady_i;
    logic            gprWriteEnable_o;
    logic [REGW-1:0] gprWriteAddress_o;
    logic [63:0]     gprWriteVal_o;
    logic            crWriteEnable_o;
    logic [REGW-1:0] crWriteAddress_o;
    logic [63:0]     crWriteVal_o;
    logic            full_o;
    logic            empty_o;
    logic [2:0]      count_o;
    logic            overflow_o;
`ifdef FXWB_FORWARD_EN
    logic [REGW-1:0] fwdAddr_i;
    logic            fwdHit_o;
    logic [63:0]     fwdVal_o;
`endif

    fx_writeback_buffer #(
        .regWidth   (REGW),
        .DEPTH      (DEPTH),
        .FXUnitCode (3'd0)
    ) dut (
        .clock_i                (clock_i),
        .reset_i                (reset_i),
        .enable_i               (enable_i),
        .functionalUnitCode_i   (functionalUnitCode_i),
        .reg1WritebackEnable_i  (reg1WritebackEnable_i),
        .reg1WritebackAddress_i (reg1WritebackAddress_i),
        .reg1WritebackVal_i     (reg1WritebackVal_i),
        .reg2WritebackEnable_i  (reg2WritebackEnable_i),
        .reg2WritebackAddress_i (reg2WritebackAddress_i),
        .reg2WritebackVal_i     (reg2WritebackVal_i),
        .writeReady_i           (writeReady_i),
        .gprWriteEnable_o       (gprWriteEnable_o),
        .gprWriteAddress_o      (gprWriteAddress_o),
        .gprWriteVal_o          (gprWriteVal_o),
        .crWriteEnable_o        (crWriteEnable_o),
        .crWriteAddress_o       (crWriteAddress_o),
        .crWriteVal_o           (crWriteVal_o),
        .full_o                 (full_o),
        .empty_o                (empty_o),
        .count_o                (count_o),
        .overflow_o             (overflow_o)
`ifdef FXWB_FORWARD_EN
        ,
        .fwdAddr_i              (fwdAddr_i),
        .fwdHit_o               (fwdHit_o),
        .fwdVal_o               (fwdVal_o)
`endif
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    int         nChecks = 0;
    int         nPassed = 0;
    ent_t       modelQ[$];
    logic       modelOverflow = 1'b0;
    logic [4:0] modelFwdAddr = '0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got === exp) begin
            nPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected outputs follow directly from the head of the reference queue.
    task automatic checkAll();
        ent_t        h;
        logic        has;
        logic        hit;
        logic [63:0] val;
        has = (modelQ.size() > 0);
        h   = has ? modelQ[0] : '{e1: 1'b0, a1: '0, v1: '0, e2: 1'b0, a2: '0, v2: '0};
        checkOutput("gpr_en",   gprWriteEnable_o,  has && h.e1);
        checkOutput("gpr_addr", gprWriteAddress_o, (has && h.e1) ? h.a1 : 5'd0);
        checkOutput("gpr_val",  gprWriteVal_o,     (has && h.e1) ? h.v1 : 64'd0);
        checkOutput("cr_en",    crWriteEnable_o,   has && h.e2);
        checkOutput("cr_addr",  crWriteAddress_o,  (has && h.e2) ? h.a2 : 5'd0);
        checkOutput("cr_val",   crWriteVal_o,      (has && h.e2) ? h.v2 : 64'd0);
        checkOutput("full",     full_o,            modelQ.size() == DEPTH);
        checkOutput("empty",    empty_o,           modelQ.size() == 0);
        checkOutput("count",    count_o,           modelQ.size());
        checkOutput("overflow", overflow_o,        modelOverflow);
        hit = 1'b0;
        val = '0;
        foreach (modelQ[k]) begin
            if (modelQ[k].e1 && modelQ[k].a1 == modelFwdAddr) begin
                hit = 1'b1;
                val = modelQ[k].v1;
            end
        end
`ifdef FXWB_FORWARD_EN
        checkOutput("fwd_hit", fwdHit_o, hit);
        checkOutput("fwd_val", fwdVal_o, val);
`endif
    endtask

    // One clock cycle: drive inputs, check current state, then advance the model.
    task automatic applyStimulus(
        input logic en, input logic [2:0] fu,
        input logic e1, input logic [4:0] a1, input logic [63:0] v1,
        input logic e2, input logic [4:0] a2, input logic [63:0] v2,
        input logic rdy, input logic [4:0] fa
    );
        logic popM;
        logic accept;
        logic wasFull;
        ent_t e;
        enable_i               = en;
        functionalUnitCode_i   = fu;
        reg1WritebackEnable_i  = e1;
        reg1WritebackAddress_i = a1;
        reg1WritebackVal_i     = v1;
        reg2WritebackEnable_i  = e2;
        reg2WritebackAddress_i = a2;
        reg2WritebackVal_i     = v2;
        writeReady_i           = rdy;
        modelFwdAddr           = fa;
`ifdef FXWB_FORWARD_EN
        fwdAddr_i              = fa;
`endif
        #1;
        checkAll();
        @(posedge clock_i);
        popM    = (modelQ.size() > 0) && rdy;
        accept  = en && (fu == 3'd0) && (e1 || e2);
        wasFull = (modelQ.size() == DEPTH);
        e       = '{e1: e1, a1: a1, v1: v1, e2: e2, a2: a2, v2: v2};
        if (popM) modelQ.delete(0);
        if (accept) begin
            if (!wasFull || popM) modelQ.push_back(e);
            else modelOverflow = 1'b1;
        end
        @(negedge clock_i);
    endtask

    task automatic idle(input logic rdy, input logic [4:0] fa);
        applyStimulus(1'b0, 3'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, rdy, fa);
    endtask

    task automatic pushGpr(input logic [4:0] a, input logic [63:0] v, input logic rdy);
        applyStimulus(1'b1, 3'd0, 1'b1, a, v, 1'b0, 5'd0, 64'd0, rdy, 5'd0);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic doReset();
        #2;
        reset_i  = 1'b0;
        enable_i = 1'b0;
        modelQ.delete();
        modelOverflow = 1'b0;
        #1;
        checkAll();
        @(negedge clock_i);
        reset_i = 1'b1;
    endtask

    initial begin
        reset_i = 1'b0;
        enable_i = 1'b0;
        functionalUnitCode_i = '0;
        reg1WritebackEnable_i = 1'b0;
        reg1WritebackAddress_i = '0;
        reg1WritebackVal_i = '0;
        reg2WritebackEnable_i = 1'b0;
        reg2WritebackAddress_i = '0;
        reg2WritebackVal_i = '0;
        writeReady_i = 1'b0;
`ifdef FXWB_FORWARD_EN
        fwdAddr_i = '0;
`endif
        #1;
        checkAll();
        @(negedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b1;

        $display("[TB] single push with ready");
        pushGpr(5'd3, 64'h5, 1'b1);
        idle(1'b1, 5'd3);
        idle(1'b1, 5'd3);

        $display("[TB] fill, overflow, push+pop while full, drain");
        for (int i = 0; i < 5; i++) pushGpr(5'(i + 10), 64'h1000 + 64'(i), 1'b0);
        pushGpr(5'd20, 64'hDEAD_BEEF_0000_0001, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b1, 5'd20);

        $display("[TB] forwarding, youngest wins");
        pushGpr(5'd7, 64'd1, 1'b0);
        pushGpr(5'd7, 64'd2, 1'b0);
        applyStimulus(1'b1, 3'd0, 1'b0, 5'd7, 64'd9, 1'b1, 5'd2, 64'hC0, 1'b0, 5'd7);
        idle(1'b0, 5'd7);
        idle(1'b0, 5'd8);
        for (int i = 0; i < 4; i++) idle(1'b1, 5'd7);

        $display("[TB] rejected pushes");
        applyStimulus(1'b1, 3'd1, 1'b1, 5'd4, 64'd44, 1'b1, 5'd1, 64'd11, 1'b0, 5'd4);
        applyStimulus(1'b1, 3'd0, 1'b0, 5'd4, 64'd44, 1'b0, 5'd1, 64'd11, 1'b0, 5'd4);
        idle(1'b0, 5'd4);

        $display("[TB] reset mid-drain");
        for (int i = 0; i < 3; i++) pushGpr(5'(i + 1), 64'h77 + 64'(i), 1'b0);
        idle(1'b1, 5'd1);
        doReset();
        idle(1'b0, 5'd1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            logic       en;
            logic [2:0] fu;
            logic       rdy;
            en  = ($urandom_range(0, 9) < 7);
            fu  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            rdy = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
            if (i == 250) doReset();
            applyStimulus(en, fu,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                          rdy, 5'($urandom_range(0, 8)));
        end

        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
